// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory
// over a req/ready handshake, and presents them to the decoder on IR.
module fetch_unit #(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_program,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] IR,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] PC,
    output logic              halted
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_STOP  = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] ir_reg, ir_next;
    logic              ir_valid_reg, ir_valid_next;
    logic              halted_reg, halted_next;
    logic              mem_req_reg, mem_req_next;
    logic              xfer_done;
    logic              is_halt_op;

    assign xfer_done  = (state_reg == ST_FETCH) && mem_req_reg && mem_ready;
    assign is_halt_op = (mem_rdata[DATA_W-1 -: 4] == HALT_OP);

    // One prioritised decision per edge: freeze > branch > completion > stall.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
        ir_valid_next = ir_valid_reg;
        halted_next   = halted_reg;
        mem_req_next  = mem_req_reg;

        if (state_reg == ST_STOP) begin
            mem_req_next = 1'b0;
        end else if (halt_program) begin
            mem_req_next = 1'b0;
        end else if (branch_taken) begin
            pc_next       = branch_target;
            ir_valid_next = 1'b0;
            state_next    = ST_FETCH;
            mem_req_next  = 1'b1;
        end else if (xfer_done) begin
            ir_next       = mem_rdata;
            ir_valid_next = 1'b1;
            if (is_halt_op) begin
                halted_next  = 1'b1;
                state_next   = ST_STOP;
                mem_req_next = 1'b0;
            end else begin
                pc_next      = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
                mem_req_next = 1'b1;
            end
        end else if (state_reg == ST_FETCH) begin
            if (stall && ir_valid_reg) begin
                state_next   = ST_HOLD;
                mem_req_next = 1'b0;
            end else begin
                mem_req_next = 1'b1;
            end
        end else if (state_reg == ST_HOLD) begin
            if (!stall) begin
                state_next   = ST_FETCH;
                mem_req_next = 1'b1;
            end else begin
                mem_req_next = 1'b0;
            end
        end else begin
            state_next   = ST_FETCH;
            mem_req_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_FETCH;
            pc_reg       <= RESET_PC;
            ir_reg       <= '0;
            ir_valid_reg <= 1'b0;
            halted_reg   <= 1'b0;
            mem_req_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_valid_reg <= ir_valid_next;
            halted_reg   <= halted_next;
            mem_req_reg  <= mem_req_next;
        end
    end

    assign mem_req  = mem_req_reg;
    assign mem_addr = pc_reg;
    assign IR       = ir_reg;
    assign ir_valid = ir_valid_reg;
    assign PC       = pc_reg;
    assign halted   = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a word-addressed memory model plus a queue of expected
// IR/PC results checked after each completing transfer.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        halt_program;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] IR;
    logic        ir_valid;
    logic [11:0] PC;
    logic        halted;

    logic [15:0] memory [0:4095];

    typedef struct packed {
        logic [15:0] ir;
        logic [11:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .halt_program  (halt_program),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .IR            (IR),
        .ir_valid      (ir_valid),
        .PC            (PC),
        .halted        (halted)
    );

    assign mem_rdata = memory[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare_sb();
        exp_t e;
        check_val("sb_pending", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("ir", IR, e.ir);
            check_val("ir_valid", ir_valid, 1);
            check_val("pc", PC, e.pc);
        end
    endtask

    // Drive a completing transfer at addr and check the result one edge later.
    task automatic expect_fetch(input logic [11:0] addr, input logic [11:0] next_pc);
        exp_t e;
        check_val("req_before", mem_req, 1);
        check_val("addr_before", mem_addr, addr);
        e.ir = memory[addr];
        e.pc = next_pc;
        sb_q.push_back(e);
        mem_ready = 1'b1;
        tick();
        compare_sb();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) memory[i] = 16'h0000;
        memory[0]     = 16'h1001;
        memory[1]     = 16'h2002;
        memory[2]     = 16'h3003;
        memory[3]     = 16'h4004;
        memory[4]     = 16'h0A04;
        memory[5]     = 16'h5005;
        memory[12'h080] = 16'hF000;
        memory[12'hFFF] = 16'h1234;

        rst = 1'b0; halt_program = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 12'h000; mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        check_val("rst_ir", IR, 16'h0000);
        check_val("rst_ir_valid", ir_valid, 0);
        check_val("rst_mem_req", mem_req, 0);
        check_val("rst_mem_addr", mem_addr, 12'h000);
        check_val("rst_pc", PC, 12'h000);
        check_val("rst_halted", halted, 0);

        // Zero-wait memory: one word per cycle after the request comes up.
        rst = 1'b1; mem_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) expect_fetch(12'(i), 12'(i + 1));
        check_val("pc_after_four", PC, 12'h004);
        expect_fetch(12'h004, 12'h005);

        // Three wait states at PC=5: request and address must stay put.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("wait_req", mem_req, 1);
            check_val("wait_addr", mem_addr, 12'h005);
            check_val("wait_ir", IR, 16'h0A04);
        end
        expect_fetch(12'h005, 12'h006);

        // Redirect to 1 so IR becomes 16'h2002; stall while IR invalid is ignored.
        mem_ready = 1'b0; branch_taken = 1'b1; branch_target = 12'h001;
        tick();
        branch_taken = 1'b0;
        check_val("br1_ir_valid", ir_valid, 0);
        check_val("br1_addr", mem_addr, 12'h001);
        stall = 1'b1;
        tick();
        check_val("stall_invalid_req", mem_req, 1);
        stall = 1'b0;
        expect_fetch(12'h001, 12'h002);

        // Two stalled cycles hold IR and drop the request.
        mem_ready = 1'b0; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("stall_ir", IR, 16'h2002);
            check_val("stall_ir_valid", ir_valid, 1);
            check_val("stall_req", mem_req, 0);
        end
        stall = 1'b0;
        tick();
        check_val("resume_req", mem_req, 1);
        check_val("resume_addr", mem_addr, 12'h002);
        expect_fetch(12'h002, 12'h003);

        // Branch on the same edge as a completion: the word is dropped.
        mem_ready = 1'b1; branch_taken = 1'b1; branch_target = 12'h040;
        tick();
        branch_taken = 1'b0; mem_ready = 1'b0;
        check_val("brx_ir", IR, 16'h3003);
        check_val("brx_ir_valid", ir_valid, 0);
        check_val("brx_addr", mem_addr, 12'h040);
        check_val("brx_req", mem_req, 1);

        // PC wraps from 12'hFFF to 0.
        branch_taken = 1'b1; branch_target = 12'hFFF;
        tick();
        branch_taken = 1'b0;
        expect_fetch(12'hFFF, 12'h000);

        // halt_program freezes the stage and abandons the request.
        halt_program = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("hp_req", mem_req, 0);
            check_val("hp_pc", PC, 12'h000);
            check_val("hp_ir", IR, 16'h1234);
        end
        halt_program = 1'b0;
        tick();
        check_val("hp_rel_addr", mem_addr, 12'h000);
        expect_fetch(12'h000, 12'h001);

        // HALT opcode at 0x080 stops the stage; branches are ignored afterwards.
        mem_ready = 1'b0; branch_taken = 1'b1; branch_target = 12'h080;
        tick();
        branch_taken = 1'b0;
        expect_fetch(12'h080, 12'h080);
        check_val("halt_flag", halted, 1);
        check_val("halt_req", mem_req, 0);
        branch_taken = 1'b1; branch_target = 12'h040;
        tick();
        branch_taken = 1'b0;
        check_val("stop_pc", PC, 12'h080);
        check_val("stop_halted", halted, 1);
        check_val("stop_req", mem_req, 0);
        check_val("stop_ir", IR, 16'hF000);

        // Asynchronous reset mid-cycle restores everything immediately.
        #2 rst = 1'b0;
        #1;
        check_val("arst_pc", PC, 12'h000);
        check_val("arst_halted", halted, 0);
        check_val("arst_ir", IR, 16'h0000);
        check_val("arst_ir_valid", ir_valid, 0);
        check_val("arst_req", mem_req, 0);
        check_val("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
